// File: rtl/vga_sprite_module.sv
// Sprite overlay stage behind the VGA sync generator: a 16x16 monochrome sprite from an
// external ROM, bouncing one pixel per frame, with syncs delayed to match the 2-cycle pixel path.
module vga_sprite_module #(
    parameter logic [15:0] FG_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR = 16'h001F,
    parameter int unsigned X_MAX    = 784,
    parameter int unsigned Y_MAX    = 584
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        VSYNC_Sig,
    input  logic        HSYNC_Sig,
    input  logic        Ready_Sig,
    input  logic [10:0] Column_Addr_Sig,
    input  logic [10:0] Row_Addr_Sig,
    input  logic        Move_En,
    output logic [3:0]  Rom_Addr,
    input  logic [15:0] Rom_Data,
    output logic [15:0] Rgb_Sig,
    output logic        VSYNC_Out,
    output logic        HSYNC_Out
);

    localparam int unsigned AW  = 11;
    localparam int unsigned SPR = 16;
    localparam logic [AW-1:0] X_LIM = AW'(X_MAX);
    localparam logic [AW-1:0] Y_LIM = AW'(Y_MAX);

    // Encoding: bit 1 = moving left, bit 0 = moving up
    typedef enum logic [1:0] {
        RIGHT_DOWN = 2'b00,
        RIGHT_UP   = 2'b01,
        LEFT_DOWN  = 2'b10,
        LEFT_UP    = 2'b11
    } dir_t;

    dir_t          state, state_nxt;
    logic [AW-1:0] pos_x, pos_y, pos_x_nxt, pos_y_nxt;
    logic          left_nxt, up_nxt;
    logic          vsync_prev;
    logic          tick_c;

    logic [AW-1:0] col_diff, row_diff;
    logic          hit_c;
    logic          hit_q, rdy_q, vs_q, hs_q;
    logic [3:0]    off_q;

    assign tick_c = vsync_prev & ~VSYNC_Sig;

    // Direction state and position registers
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state      <= RIGHT_DOWN;
            pos_x      <= '0;
            pos_y      <= '0;
            vsync_prev <= 1'b1;
        end else begin
            state      <= state_nxt;
            pos_x      <= pos_x_nxt;
            pos_y      <= pos_y_nxt;
            vsync_prev <= VSYNC_Sig;
        end
    end

    // Bounce: step each axis once per frame tick, reflecting at the edges
    always_comb begin
        state_nxt = state;
        pos_x_nxt = pos_x;
        pos_y_nxt = pos_y;
        left_nxt  = state[1];
        up_nxt    = state[0];
        if (tick_c && Move_En) begin
            if (!state[1]) begin
                if (pos_x == X_LIM) begin
                    pos_x_nxt = pos_x - AW'(1);
                    left_nxt  = 1'b1;
                end else begin
                    pos_x_nxt = pos_x + AW'(1);
                end
            end else begin
                if (pos_x == '0) begin
                    pos_x_nxt = pos_x + AW'(1);
                    left_nxt  = 1'b0;
                end else begin
                    pos_x_nxt = pos_x - AW'(1);
                end
            end
            if (!state[0]) begin
                if (pos_y == Y_LIM) begin
                    pos_y_nxt = pos_y - AW'(1);
                    up_nxt    = 1'b1;
                end else begin
                    pos_y_nxt = pos_y + AW'(1);
                end
            end else begin
                if (pos_y == '0) begin
                    pos_y_nxt = pos_y + AW'(1);
                    up_nxt    = 1'b0;
                end else begin
                    pos_y_nxt = pos_y - AW'(1);
                end
            end
            state_nxt = dir_t'({left_nxt, up_nxt});
        end
    end

    assign col_diff = Column_Addr_Sig - pos_x;
    assign row_diff = Row_Addr_Sig - pos_y;
    assign hit_c    = Ready_Sig
                    && (Column_Addr_Sig >= pos_x) && (Column_Addr_Sig < pos_x + AW'(SPR))
                    && (Row_Addr_Sig >= pos_y)    && (Row_Addr_Sig < pos_y + AW'(SPR));

    // Stage 1: sprite hit test and ROM row fetch
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            Rom_Addr <= '0;
            off_q    <= '0;
            hit_q    <= 1'b0;
            rdy_q    <= 1'b0;
            vs_q     <= 1'b1;
            hs_q     <= 1'b1;
        end else begin
            if (hit_c) begin
                Rom_Addr <= row_diff[3:0];
            end
            off_q <= col_diff[3:0];
            hit_q <= hit_c;
            rdy_q <= Ready_Sig;
            vs_q  <= VSYNC_Sig;
            hs_q  <= HSYNC_Sig;
        end
    end

    // Stage 2: colour select; bit 15 of the ROM word is the leftmost pixel
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            Rgb_Sig   <= '0;
            VSYNC_Out <= 1'b1;
            HSYNC_Out <= 1'b1;
        end else begin
            if (!rdy_q) begin
                Rgb_Sig <= '0;
            end else if (hit_q && Rom_Data[~off_q]) begin
                Rgb_Sig <= FG_COLOR;
            end else begin
                Rgb_Sig <= BG_COLOR;
            end
            VSYNC_Out <= vs_q;
            HSYNC_Out <= hs_q;
        end
    end

endmodule

// File: tb/tb_vga_sprite_module.sv
// Scoreboard bench for vga_sprite_module: stimulus queues expected pixel/sync/ROM-address
// values, a negedge monitor pops and compares them as they become due.
module tb_vga_sprite_module;

    localparam int unsigned XM = 40;
    localparam int unsigned YM = 56;
    localparam logic [15:0] FG = 16'hFFFF;
    localparam logic [15:0] BG = 16'h001F;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        VSYNC_Sig, HSYNC_Sig, Ready_Sig, Move_En;
    logic [10:0] Column_Addr_Sig, Row_Addr_Sig;
    logic [3:0]  Rom_Addr;
    logic [15:0] Rom_Data, Rgb_Sig;
    logic        VSYNC_Out, HSYNC_Out;

    logic [15:0] rom [16];

    vga_sprite_module #(.FG_COLOR(FG), .BG_COLOR(BG), .X_MAX(XM), .Y_MAX(YM)) dut (
        .CLK(CLK), .RSTn(RSTn), .VSYNC_Sig(VSYNC_Sig), .HSYNC_Sig(HSYNC_Sig),
        .Ready_Sig(Ready_Sig), .Column_Addr_Sig(Column_Addr_Sig), .Row_Addr_Sig(Row_Addr_Sig),
        .Move_En(Move_En), .Rom_Addr(Rom_Addr), .Rom_Data(Rom_Data), .Rgb_Sig(Rgb_Sig),
        .VSYNC_Out(VSYNC_Out), .HSYNC_Out(HSYNC_Out)
    );

    // Diagonal sprite: row r lights column r, so row 0 is 16'h8000
    assign Rom_Data = rom[Rom_Addr];

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        bit          is_rom;
        logic [15:0] rgb;
        logic        vs;
        logic        hs;
        logic [3:0]  ra;
        int          tag;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    // Monitor: compare every expectation that falls due this cycle
    always @(negedge CLK) begin
        if (RSTn === 1'b1) begin
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.due < cyc) begin
                    errors++;
                    $display("FAIL stale step %0d due %0d now %0d", e.tag, e.due, cyc);
                end else if (e.is_rom) begin
                    if (Rom_Addr !== e.ra) begin
                        errors++;
                        $display("FAIL rom_addr step %0d cyc %0d got %0d want %0d",
                                 e.tag, cyc, Rom_Addr, e.ra);
                    end
                end else if ({Rgb_Sig, VSYNC_Out, HSYNC_Out} !== {e.rgb, e.vs, e.hs}) begin
                    errors++;
                    $display("FAIL pixel step %0d cyc %0d got rgb %h vs %b hs %b want rgb %h vs %b hs %b",
                             e.tag, cyc, Rgb_Sig, VSYNC_Out, HSYNC_Out, e.rgb, e.vs, e.hs);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [15:0] pix(input int c, input int r, input int x, input int y);
        if (c >= x && c < x + 16 && r >= y && r < y + 16)
            return ((c - x) == (r - y)) ? FG : BG;
        return BG;
    endfunction

    // One input cycle; rgb/syncs due 2 cycles later, Rom_Addr 1 cycle later
    task automatic drive(input logic rdy, input int col, input int row, input logic vs,
                         input logic hs, input logic [15:0] want_rgb, input bit chk_rom,
                         input logic [3:0] want_ra);
        exp_t x;
        Ready_Sig       = rdy;
        Column_Addr_Sig = 11'(col);
        Row_Addr_Sig    = 11'(row);
        VSYNC_Sig       = vs;
        HSYNC_Sig       = hs;
        if (chk_rom) begin
            x = '{due: cyc + 1, is_rom: 1'b1, rgb: 16'h0, vs: 1'b0, hs: 1'b0, ra: want_ra, tag: step};
            q.push_back(x);
        end
        x = '{due: cyc + 2, is_rom: 1'b0, rgb: want_rgb, vs: vs, hs: hs, ra: 4'h0, tag: step};
        q.push_back(x);
        @(posedge CLK);
        #1;
    endtask

    task automatic px(input int c, input int r, input int x, input int y, input bit chk_rom);
        drive(1'b1, c, r, 1'b1, 1'b1, pix(c, r, x, y), chk_rom, 4'(r - y));
    endtask

    // Confirm the sprite's top-left corner is exactly at (x,y)
    task automatic probe(input int x, input int y);
        step++;
        px(x,      y,      x, y, 1'b1);
        px(x + 1,  y,      x, y, 1'b0);
        px(x + 1,  y + 1,  x, y, 1'b1);
        px(x + 15, y + 15, x, y, 1'b1);
        px(x + 16, y,      x, y, 1'b0);
        px(x,      y + 16, x, y, 1'b0);
        if (x > 0) px(x - 1, y, x, y, 1'b0);
        drive(1'b0, x, y, 1'b1, 1'b1, 16'h0000, 1'b0, 4'h0);
    endtask

    // One frame: VSYNC falling edge outside active video, with an HSYNC pulse behind it
    task automatic frames(input int n, input logic move);
        Move_En = move;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 0, 0, 1'b0, 1'b1, 16'h0000, 1'b0, 4'h0);
            drive(1'b0, 0, 0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'h0);
        end
        Move_En = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 16'h8000 >> i;
        RSTn = 1'b0; Move_En = 1'b0; Ready_Sig = 1'b1;
        VSYNC_Sig = 1'b1; HSYNC_Sig = 1'b0;
        Column_Addr_Sig = 11'd0; Row_Addr_Sig = 11'd0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_rgb", 32'(Rgb_Sig), 32'h0);
        check("reset_vs", 32'(VSYNC_Out), 32'h1);
        check("reset_hs", 32'(HSYNC_Out), 32'h1);
        check("reset_rom_addr", 32'(Rom_Addr), 32'h0);
        RSTn = 1'b1;

        probe(0, 0);
        frames(3, 1'b1);
        probe(3, 3);
        frames(2, 1'b0);
        probe(3, 3);
        frames(37, 1'b1);
        probe(40, 40);
        frames(1, 1'b1);
        probe(39, 41);
        frames(1, 1'b1);
        probe(38, 42);
        frames(238, 1'b1);
        probe(40, 56);
        frames(1, 1'b1);
        probe(39, 55);
        frames(1, 1'b1);
        probe(38, 54);

        // Reset in the middle of an active line
        step++;
        px(38, 54, 38, 54, 1'b0);
        RSTn = 1'b0;
        Ready_Sig = 1'b1; HSYNC_Sig = 1'b0; VSYNC_Sig = 1'b1;
        q.delete();
        @(posedge CLK);
        #1;
        check("midreset_rgb", 32'(Rgb_Sig), 32'h0);
        check("midreset_vs", 32'(VSYNC_Out), 32'h1);
        check("midreset_hs", 32'(HSYNC_Out), 32'h1);
        check("midreset_rom_addr", 32'(Rom_Addr), 32'h0);
        RSTn = 1'b1;
        drive(1'b1, 0, 0, 1'b1, 1'b1, FG, 1'b1, 4'h0);
        probe(0, 0);
        frames(1, 1'b1);
        probe(1, 1);

        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
